// File: rtl/alu_shift_wb_queue_pkg.sv
// alu_shift_wb_queue_pkg: shared widths, flag bit indices and writeback entry layout
package alu_shift_wb_queue_pkg;
    localparam int FLAG_WIDTH = 6;
    localparam int REG_WIDTH  = 9;
    localparam int FLAG_C = 5;
    localparam int FLAG_O = 4;
    localparam int FLAG_A = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_P = 0;
    typedef struct packed {
        logic                  thread;
        logic [REG_WIDTH-1:0]  dst;
        logic [65:0]           val;
        logic [FLAG_WIDTH-1:0] flags;
        logic                  flag_en;
        logic                  perr;
    } wb_entry_t;
endpackage

// File: rtl/alu_wb_parity_chk.sv
// alu_wb_parity_chk: flags a result whose bit 65 is not the even parity of bits 64:0
module alu_wb_parity_chk
    import alu_shift_wb_queue_pkg::*;
(
    input  logic [65:0] val,
    output logic        perr
);
    assign perr = (^val[64:0]) != val[65];
endmodule

// File: rtl/alu_shift_wb_queue.sv
// alu_shift_wb_queue: shift-ALU result FIFO with parity check, per-thread flush and in-order drain
module alu_shift_wb_queue
    import alu_shift_wb_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int REG_WIDTH  = alu_shift_wb_queue_pkg::REG_WIDTH,
    parameter int FLAG_WIDTH = alu_shift_wb_queue_pkg::FLAG_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     except,
    input  logic                     except_thread,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic                     in_thread,
    input  logic [REG_WIDTH-1:0]     in_reg,
    input  logic [65:0]              in_val,
    input  logic [FLAG_WIDTH-1:0]    in_flags,
    input  logic                     in_flag_en,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_thread,
    output logic [REG_WIDTH-1:0]     out_reg,
    output logic [65:0]              out_val,
    output logic [FLAG_WIDTH-1:0]    out_flags,
    output logic                     out_flag_en,
    output logic                     out_perr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic                  thread;
        logic [REG_WIDTH-1:0]  dst;
        logic [65:0]           val;
        logic [FLAG_WIDTH-1:0] flags;
        logic                  flag_en;
        logic                  perr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            in_perr, nonempty, head_flushed, push, pop, skip;
    entry_t          head;

    alu_wb_parity_chk u_par (.val(in_val), .perr(in_perr));

    assign nonempty     = count != '0;
    assign in_rdy       = count != CW'(DEPTH);
    assign out_vld      = nonempty && vld[rd_ptr];
    assign head_flushed = except && mem[rd_ptr].thread == except_thread;
    assign push         = in_vld && in_rdy && !(except && in_thread == except_thread);
    assign pop          = out_vld && out_rdy && !head_flushed;
    assign skip         = nonempty && !vld[rd_ptr];
    assign head         = out_vld ? mem[rd_ptr] : '0;
    assign out_thread   = head.thread;
    assign out_reg      = head.dst;
    assign out_val      = head.val;
    assign out_flags    = head.flags;
    assign out_flag_en  = head.flag_en;
    assign out_perr     = head.perr;

    // Payload storage; only the valid bits need reset, stale payload is masked off at the output
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_thread, in_reg, in_val, in_flags, in_flag_en, in_perr};
    end

    // Pointers, occupancy, valid bits (flush clears, push sets, pop clears) and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
            ovf    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (except && mem[i].thread == except_thread) vld[i] <= 1'b0;
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) vld[rd_ptr] <= 1'b0;
            if (pop || skip) rd_ptr <= rd_ptr + 1'b1;
            if (in_vld && !in_rdy) ovf <= 1'b1;
            count <= count + CW'(push) - CW'(pop || skip);
        end
    end
endmodule

// File: tb/tb_alu_shift_wb_queue.sv
// tb_alu_shift_wb_queue: directed checks of push/pop, overflow, parity, flush/skip and async reset
module tb_alu_shift_wb_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        except = 1'b0, except_thread = 1'b0;
    logic        in_vld = 1'b0, in_rdy, in_thread = 1'b0;
    logic [8:0]  in_reg = '0;
    logic [65:0] in_val = '0;
    logic [5:0]  in_flags = '0;
    logic        in_flag_en = 1'b0;
    logic        out_vld, out_rdy = 1'b0, out_thread;
    logic [8:0]  out_reg;
    logic [65:0] out_val;
    logic [5:0]  out_flags;
    logic        out_flag_en, out_perr;
    logic [2:0]  count;
    logic        ovf;
    int          checks = 0, errors = 0;

    alu_shift_wb_queue dut (
        .clk(clk), .rst(rst), .except(except), .except_thread(except_thread),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_thread(in_thread), .in_reg(in_reg),
        .in_val(in_val), .in_flags(in_flags), .in_flag_en(in_flag_en),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_thread(out_thread), .out_reg(out_reg),
        .out_val(out_val), .out_flags(out_flags), .out_flag_en(out_flag_en),
        .out_perr(out_perr), .count(count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] gv(input logic [64:0] x);
        return {^x, x};
    endfunction

    task automatic push(input logic th, input logic [8:0] r, input logic [65:0] v);
        in_vld = 1'b1; in_thread = th; in_reg = r; in_val = v;
        tick();
        in_vld = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_val", out_val, 0);
        chk("rst_out_reg", out_reg, 0);
        rst = 1'b1;
        tick();

        push(0, 9'd1, gv(65'd1));
        chk("lat_out_vld", out_vld, 1);
        chk("lat_out_reg", out_reg, 1);
        chk("lat_out_perr", out_perr, 0);
        push(0, 9'd2, gv(65'd2));
        push(0, 9'd3, gv(65'd3));
        push(0, 9'd4, gv(65'd4));
        chk("full_in_rdy", in_rdy, 0);
        chk("full_count", count, 4);
        chk("full_ovf_clear", ovf, 0);
        push(0, 9'd9, gv(65'd9));
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, 4);
        chk("ovf_head", out_reg, 1);

        out_rdy = 1'b1;
        push(0, 9'd5, gv(65'd5));
        out_rdy = 1'b0;
        chk("fullpp_count", count, 3);
        chk("fullpp_in_rdy", in_rdy, 1);
        chk("fullpp_head", out_reg, 2);
        push(0, 9'd6, gv(65'd6));
        chk("refill_count", count, 4);
        out_rdy = 1'b1;
        tick();
        chk("drain_h3", out_reg, 3);
        chk("drain_v3", out_val, 66'h3);
        tick();
        chk("drain_h4", out_reg, 4);
        chk("drain_v4", out_val, 66'h2_0000_0000_0000_0004);
        tick();
        chk("drain_h6", out_reg, 6);
        tick();
        chk("drain_count", count, 0);
        chk("drain_out_vld", out_vld, 0);
        out_rdy = 1'b0;

        in_flags = 6'b100001; in_flag_en = 1'b1;
        push(1, 9'd7, 66'h0_0000_0000_0000_0003);
        in_flags = '0; in_flag_en = 1'b0;
        chk("par_ok_vld", out_vld, 1);
        chk("par_ok_val", out_val, 66'h3);
        chk("par_ok_perr", out_perr, 0);
        chk("par_ok_flags", out_flags, 6'b100001);
        chk("par_ok_fen", out_flag_en, 1);
        chk("par_ok_thread", out_thread, 1);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("par_pop_count", count, 0);
        push(0, 9'd8, 66'h2_0000_0000_0000_0003);
        chk("par_bad_vld", out_vld, 1);
        chk("par_bad_val", out_val, 66'h2_0000_0000_0000_0003);
        chk("par_bad_perr", out_perr, 1);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("par_bad_pop", count, 0);

        push(0, 9'd1, gv(65'd11));
        push(1, 9'd2, gv(65'd12));
        push(0, 9'd3, gv(65'd13));
        push(1, 9'd4, gv(65'd14));
        chk("mix_count", count, 4);
        except = 1'b1; except_thread = 1'b0; out_rdy = 1'b1;
        tick();
        except = 1'b0;
        chk("flush_no_pop", count, 4);
        chk("flush_out_vld", out_vld, 0);
        tick();
        chk("skip1_count", count, 3);
        chk("skip1_head", out_reg, 2);
        chk("skip1_vld", out_vld, 1);
        tick();
        chk("pop1_count", count, 2);
        chk("pop1_vld", out_vld, 0);
        tick();
        chk("skip2_count", count, 1);
        chk("skip2_head", out_reg, 4);
        tick();
        chk("pop2_count", count, 0);
        chk("pop2_vld", out_vld, 0);
        out_rdy = 1'b0;

        push(0, 9'd7, gv(65'd7));
        except = 1'b1; except_thread = 1'b1;
        push(1, 9'd8, gv(65'd8));
        except = 1'b0;
        chk("xpush_count", count, 1);
        chk("xpush_head", out_reg, 7);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("xpush_empty", count, 0);
        chk("xpush_vld", out_vld, 0);

        push(0, 9'd1, gv(65'd1));
        push(1, 9'd2, gv(65'd2));
        push(0, 9'd3, gv(65'd3));
        chk("pre_arst_count", count, 3);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_vld", out_vld, 0);
        chk("arst_count", count, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_in_rdy", in_rdy, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("post_arst_vld", out_vld, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
